ccip_c0_read_arbiter: RTL and testbench
=======================================

# ccip_c0_read_arbiter

Round-robin arbiter that shares the CCI-P c0 Tx read-request channel among NUM_REQ AFU-side requesters and steers c0 Rx read responses back to the issuing requester. It sits in the AFU clock domain between the AFU's internal engines and the CCI-P port of the platform shim. It tags each request with the requester ID in the upper mdata bits and enforces a per-requester outstanding-read limit. It stops issuing whenever the FIU asserts c0TxAlmFull.

## Interface
Parameters:
- NUM_REQ, default 4: number of requesters; legal range 2..16.
- MAX_OUTSTANDING, default 64: maximum in-flight reads per requester; legal range 1..255.

Ports:
- pClk  in  1  CCI-P clock; all logic is in this domain.
- pck_cp2af_softReset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester read request valid.
- req_addr  in  NUM_REQ*42  per-requester cache-line address; slice i is bits [42*i+41:42*i].
- req_mdata  in  NUM_REQ*12  per-requester user tag; slice i is bits [12*i+11:12*i].
- req_ready  out  NUM_REQ  request accepted this cycle; combinational, one-hot or zero.
- c0TxAlmFull  in  1  FIU c0 Tx almost-full.
- c0Tx_valid  out  1  read request to FIU.
- c0Tx_addr  out  42  request address.
- c0Tx_mdata  out  16  {requester ID[3:0], req_mdata[11:0]}.
- c0Rx_rspValid  in  1  read response valid; the only responses presented are read responses.
- c0Rx_mdata  in  16  response mdata.
- c0Rx_data  in  512  response data.
- rsp_valid  out  NUM_REQ  one-hot response strobe to the owning requester.
- rsp_mdata  out  12  returned user tag.
- rsp_data  out  512  returned line.
- err_bad_id  out  1  sticky flag: a response carried an ID >= NUM_REQ.
- busy  out  1  high while any outstanding counter is nonzero.

## Operation
- Eligibility: requester i is eligible when req_valid[i] is high and cnt[i] < MAX_OUTSTANDING.
- Grant:
  - When c0TxAlmFull is low, select the first eligible requester at or after rr_ptr, wrapping modulo NUM_REQ. Set req_ready for that requester only.
  - When c0TxAlmFull is high, or no requester is eligible, req_ready is all zero.
- Pointer: on a grant to requester w, rr_ptr becomes (w+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Issue: the granted request is registered. On the next cycle, c0Tx_valid=1, c0Tx_addr=req_addr[w], c0Tx_mdata={w[3:0], req_mdata[w]}. Otherwise c0Tx_valid=0, and addr/mdata hold their last values.
- Response routing:
  - When c0Rx_rspValid is high, id = c0Rx_mdata[15:12].
  - If id < NUM_REQ: on the next cycle rsp_valid[id]=1, rsp_mdata=c0Rx_mdata[11:0], rsp_data=c0Rx_data.
  - If id >= NUM_REQ: the response is dropped, err_bad_id is set, and no counter changes.
- Counters: cnt[i] is 8 bits.
  - +1 on a grant to i; -1 on a valid response to i; unchanged when both happen in the same cycle.
  - A response arriving while cnt[i]==0 is treated as bad: it sets err_bad_id and the counter does not decrement (no underflow). The response is still forwarded.
- busy = OR of (cnt[i] != 0).
- Reset: on assertion, asynchronously clear all of the following immediately:
  - c0Tx_valid=0, c0Tx_addr=0, c0Tx_mdata=0
  - rsp_valid=0, rsp_mdata=0, rsp_data=0
  - err_bad_id=0, busy=0, rr_ptr=0, all cnt=0
  - A request registered but not yet presented is discarded.
  - Responses arriving during reset are ignored.
  - err_bad_id clears only on reset.

## Timing
- Request path: req_valid&req_ready at cycle N produces c0Tx_valid at N+1. The issue path sustains one request per cycle.
- c0TxAlmFull sampled high at cycle N blocks grants at N. A request granted at N-1 still appears at N; that is the single permitted in-flight issue.
- Response path: c0Rx_rspValid at N produces rsp_valid at N+1. A response every cycle is accepted; there is no backpressure on the response path.
- The counter update from a grant or response at N is visible to the eligibility check at N+1.
- Worst-case grant latency for a continuously valid, eligible requester is NUM_REQ-1 cycles.

## Test plan
- Reset values: hold reset low, drive all inputs random -> every output is 0. Release reset; first grant goes to requester 0 if valid.
- Round robin: NUM_REQ=4, all four valid continuously, almFull=0 -> grants 0,1,2,3,0,… one per cycle. c0Tx_mdata[15:12] follows the same sequence, one cycle later.
- Backpressure: almFull high at cycles 10-14 while all requesters are valid -> req_ready is 0 at cycles 10-14 and c0Tx_valid is 0 at cycles 11-15. Grants resume at cycle 15 from the saved rr_ptr.
- Outstanding limit: MAX_OUTSTANDING=2, requester 1 only, no responses -> two grants, then req_ready[1]=0. Return one response with mdata 16'h1ABC -> rsp_valid=4'b0010 and rsp_mdata=12'hABC one cycle later; the next grant follows the cycle after that.
- Simultaneous events: a grant to requester 2 and a response with ID 2 in the same cycle, with cnt[2]=5 -> cnt[2] stays 5.
- Bad ID: response with mdata 16'hF000 at NUM_REQ=4 -> no rsp_valid, err_bad_id=1 from the next cycle, sticky until reset.

Source files
------------

// File: rtl/ccip_c0_read_arbiter.sv
// Round-robin sharing of the CCI-P c0 read-request channel among NUM_REQ requesters.
// Requester ID travels in c0Tx_mdata[15:12] and steers the c0 read response back to its owner.
module ccip_c0_read_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                  pClk,
    input  logic                  pck_cp2af_softReset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*42-1:0] req_addr,
    input  logic [NUM_REQ*12-1:0] req_mdata,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  c0TxAlmFull,
    output logic                  c0Tx_valid,
    output logic [41:0]           c0Tx_addr,
    output logic [15:0]           c0Tx_mdata,
    input  logic                  c0Rx_rspValid,
    input  logic [15:0]           c0Rx_mdata,
    input  logic [511:0]          c0Rx_data,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [11:0]           rsp_mdata,
    output logic [511:0]          rsp_data,
    output logic                  err_bad_id,
    output logic                  busy
);

    localparam int                PTR_W      = $clog2(NUM_REQ);
    localparam int                CW         = PTR_W + 1;
    localparam logic [CW-1:0]     NUM_REQ_P  = CW'(NUM_REQ);
    localparam logic [PTR_W-1:0]  LAST_P     = PTR_W'(NUM_REQ - 1);
    localparam logic [4:0]        NUM_REQ_ID = 5'(NUM_REQ);
    localparam logic [7:0]        MAX_CNT    = 8'(MAX_OUTSTANDING);

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]         cnt_q [NUM_REQ];
    logic [7:0]         cnt_d [NUM_REQ];
    logic               c0Tx_valid_q, c0Tx_valid_d;
    logic [41:0]        c0Tx_addr_q, c0Tx_addr_d;
    logic [15:0]        c0Tx_mdata_q, c0Tx_mdata_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [11:0]        rsp_mdata_q, rsp_mdata_d;
    logic [511:0]       rsp_data_q, rsp_data_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] eligible;
    logic               win_any;
    logic [PTR_W-1:0]   win_idx;
    logic               grant_vld;
    logic [3:0]         rsp_id;
    logic [PTR_W-1:0]   rsp_idx;
    logic               rsp_hit;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (cnt_q[i] < MAX_CNT);
        end
    end

    // Scan from rr_ptr upward, wrapping at NUM_REQ (which need not be a power of two).
    always_comb begin
        logic [CW-1:0] cand;
        cand    = '0;
        win_any = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + CW'(k);
            if (cand >= NUM_REQ_P) begin
                cand = cand - NUM_REQ_P;
            end
            if (!win_any && eligible[cand[PTR_W-1:0]]) begin
                win_any = 1'b1;
                win_idx = cand[PTR_W-1:0];
            end
        end
        grant_vld = win_any && !c0TxAlmFull && pck_cp2af_softReset_n;
    end

    always_comb begin
        req_ready = '0;
        if (grant_vld) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        c0Tx_valid_d = grant_vld;
        c0Tx_addr_d  = c0Tx_addr_q;
        c0Tx_mdata_d = c0Tx_mdata_q;
        if (grant_vld) begin
            rr_ptr_d = (win_idx == LAST_P) ? '0 : win_idx + PTR_W'(1);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vld && (win_idx == PTR_W'(i))) begin
                c0Tx_addr_d  = req_addr[42*i +: 42];
                c0Tx_mdata_d = {4'(i), req_mdata[12*i +: 12]};
            end
        end
    end

    assign rsp_id  = c0Rx_mdata[15:12];
    assign rsp_idx = rsp_id[PTR_W-1:0];
    assign rsp_hit = c0Rx_rspValid && ({1'b0, rsp_id} < NUM_REQ_ID);

    // A response to an idle counter is still forwarded but flagged and never underflows.
    always_comb begin
        logic inc;
        logic dec;
        inc         = 1'b0;
        dec         = 1'b0;
        rsp_valid_d = '0;
        rsp_mdata_d = rsp_mdata_q;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q;
        if (c0Rx_rspValid && !rsp_hit) begin
            err_d = 1'b1;
        end
        if (rsp_hit) begin
            rsp_valid_d[rsp_idx] = 1'b1;
            rsp_mdata_d          = c0Rx_mdata[11:0];
            rsp_data_d           = c0Rx_data;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            inc      = grant_vld && (win_idx == PTR_W'(i));
            dec      = rsp_hit && (rsp_idx == PTR_W'(i));
            cnt_d[i] = cnt_q[i];
            if (dec && (cnt_q[i] == 8'd0)) begin
                err_d = 1'b1;
                dec   = 1'b0;
            end
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - 8'd1;
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            busy = busy | (cnt_q[i] != 8'd0);
        end
    end

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            rr_ptr_q     <= '0;
            c0Tx_valid_q <= 1'b0;
            c0Tx_addr_q  <= '0;
            c0Tx_mdata_q <= '0;
            rsp_valid_q  <= '0;
            rsp_mdata_q  <= '0;
            rsp_data_q   <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            c0Tx_valid_q <= c0Tx_valid_d;
            c0Tx_addr_q  <= c0Tx_addr_d;
            c0Tx_mdata_q <= c0Tx_mdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_mdata_q  <= rsp_mdata_d;
            rsp_data_q   <= rsp_data_d;
            err_q        <= err_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign c0Tx_valid = c0Tx_valid_q;
    assign c0Tx_addr  = c0Tx_addr_q;
    assign c0Tx_mdata = c0Tx_mdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_mdata  = rsp_mdata_q;
    assign rsp_data   = rsp_data_q;
    assign err_bad_id = err_q;

endmodule

// File: tb/tb_ccip_c0_read_arbiter.sv
// Scoreboard bench for ccip_c0_read_arbiter: a per-cycle reference model predicts grants and
// pushes expected c0Tx / response beats into queues that a negedge monitor pops and compares.
module tb_ccip_c0_read_arbiter;

    localparam int N    = 4;
    localparam int MAXO = 2;

    logic              pClk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid;
    logic [N*42-1:0]   req_addr;
    logic [N*12-1:0]   req_mdata;
    logic [N-1:0]      req_ready;
    logic              alm;
    logic              c0Tx_valid;
    logic [41:0]       c0Tx_addr;
    logic [15:0]       c0Tx_mdata;
    logic              c0Rx_rspValid;
    logic [15:0]       c0Rx_mdata;
    logic [511:0]      c0Rx_data;
    logic [N-1:0]      rsp_valid;
    logic [11:0]       rsp_mdata;
    logic [511:0]      rsp_data;
    logic              err_bad_id;
    logic              busy;

    ccip_c0_read_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
        .pClk                  (pClk),
        .pck_cp2af_softReset_n (rst_n),
        .req_valid             (req_valid),
        .req_addr              (req_addr),
        .req_mdata             (req_mdata),
        .req_ready             (req_ready),
        .c0TxAlmFull           (alm),
        .c0Tx_valid            (c0Tx_valid),
        .c0Tx_addr             (c0Tx_addr),
        .c0Tx_mdata            (c0Tx_mdata),
        .c0Rx_rspValid         (c0Rx_rspValid),
        .c0Rx_mdata            (c0Rx_mdata),
        .c0Rx_data             (c0Rx_data),
        .rsp_valid             (rsp_valid),
        .rsp_mdata             (rsp_mdata),
        .rsp_data              (rsp_data),
        .err_bad_id            (err_bad_id),
        .busy                  (busy)
    );

    always #5 pClk = ~pClk;

    typedef struct {
        int          cyc;
        logic [41:0] addr;
        logic [15:0] mdata;
    } tx_t;

    typedef struct {
        int           cyc;
        logic [N-1:0] vec;
        logic [11:0]  mdata;
        logic [511:0] data;
    } rx_t;

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    tx_t txq[$];
    rx_t rxq[$];
    int  pend[$];
    int  m_cnt[N];
    int  m_rr;
    bit  m_err;

    always @(posedge pClk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge pClk) begin
        bit exp_tx;
        bit exp_rx;
        exp_tx = (txq.size() > 0) && (txq[0].cyc == cyc);
        check("c0Tx_valid", c0Tx_valid, exp_tx);
        if (exp_tx) begin
            check("c0Tx_addr", c0Tx_addr, txq[0].addr);
            check("c0Tx_mdata", c0Tx_mdata, txq[0].mdata);
            void'(txq.pop_front());
        end
        exp_rx = (rxq.size() > 0) && (rxq[0].cyc == cyc);
        check("rsp_valid", rsp_valid, exp_rx ? rxq[0].vec : '0);
        if (exp_rx) begin
            check("rsp_mdata", rsp_mdata, rxq[0].mdata);
            check("rsp_data", rsp_data, rxq[0].data);
            void'(rxq.pop_front());
        end
    end

    function automatic bit model_busy();
        for (int i = 0; i < N; i++) if (m_cnt[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_rr  = 0;
        m_err = 1'b0;
        txq.delete();
        rxq.delete();
        pend.delete();
    endtask

    // One clock: predict from the inputs already driven, compare, update model.
    task automatic step();
        int           g;
        int           id;
        logic [N-1:0] exp_rdy;
        tx_t          t;
        rx_t          r;
        @(negedge pClk);
        g = -1;
        if (!alm) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_rr + k) % N;
                if (req_valid[i] && m_cnt[i] < MAXO) begin
                    g = i;
                    break;
                end
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        check("busy", busy, model_busy());
        check("err_bad_id", err_bad_id, m_err);
        if (c0Rx_rspValid) begin
            id = int'(c0Rx_mdata[15:12]);
            if (id >= N) begin
                m_err = 1'b1;
            end else begin
                r.cyc   = cyc + 1;
                r.vec   = '0;
                r.vec[id] = 1'b1;
                r.mdata = c0Rx_mdata[11:0];
                r.data  = c0Rx_data;
                rxq.push_back(r);
                if (m_cnt[id] == 0) m_err = 1'b1;
                else m_cnt[id]--;
            end
        end
        if (g >= 0) begin
            t.cyc   = cyc + 1;
            t.addr  = req_addr[g*42 +: 42];
            t.mdata = {4'(g), req_mdata[g*12 +: 12]};
            txq.push_back(t);
            m_rr = (g + 1) % N;
            m_cnt[g]++;
            pend.push_back(g);
        end
        @(posedge pClk);
        #1;
    endtask

    task automatic rand_data();
        for (int w = 0; w < 16; w++) c0Rx_data[w*32 +: 32] = $urandom;
    endtask

    task automatic rand_req(input int pct);
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = ($urandom_range(99) < pct);
            req_addr[i*42 +: 42]  = 42'({$urandom, $urandom});
            req_mdata[i*12 +: 12] = 12'($urandom);
        end
    endtask

    // Respond to the oldest outstanding request, if any.
    task automatic set_rsp(input bit en);
        rand_data();
        c0Rx_mdata = 16'($urandom);
        if (en && pend.size() > 0) begin
            c0Rx_rspValid = 1'b1;
            c0Rx_mdata    = {4'(pend.pop_front()), 12'($urandom)};
        end else begin
            c0Rx_rspValid = 1'b0;
        end
    endtask

    task automatic drain();
        req_valid = '0;
        alm       = 1'b0;
        while (pend.size() > 0) begin
            set_rsp(1'b1);
            step();
        end
        set_rsp(1'b0);
        step();
    endtask

    task automatic check_zero();
        check("rst_req_ready", req_ready, '0);
        check("rst_c0Tx_valid", c0Tx_valid, '0);
        check("rst_c0Tx_addr", c0Tx_addr, '0);
        check("rst_c0Tx_mdata", c0Tx_mdata, '0);
        check("rst_rsp_valid", rsp_valid, '0);
        check("rst_rsp_mdata", rsp_mdata, '0);
        check("rst_rsp_data", rsp_data, '0);
        check("rst_err_bad_id", err_bad_id, '0);
        check("rst_busy", busy, '0);
    endtask

    initial begin
        model_reset();
        rand_req(100);
        alm = 1'b0;
        c0Rx_rspValid = 1'b0;
        c0Rx_mdata = '0;
        c0Rx_data = '0;

        // Reset held with random inputs: all outputs quiet.
        repeat (4) begin
            @(negedge pClk);
            rand_req(100);
            alm           = 1'($urandom);
            c0Rx_rspValid = 1'b1;
            c0Rx_mdata    = 16'($urandom);
            rand_data();
            #1 check_zero();
        end
        @(posedge pClk);
        #1;
        rst_n = 1'b1;

        // Round robin with backpressure window on steps 10..14.
        rand_req(100);
        req_valid = '1;
        for (int c = 0; c < 20; c++) begin
            alm = (c >= 10 && c <= 14);
            set_rsp(1'b1);
            step();
        end
        drain();

        // Outstanding limit on requester 1.
        rand_req(0);
        req_valid = 4'b0010;
        set_rsp(1'b0);
        repeat (4) step();
        void'(pend.pop_front());
        c0Rx_rspValid = 1'b1;
        c0Rx_mdata    = 16'h1ABC;
        rand_data();
        step();
        set_rsp(1'b0);
        repeat (3) step();
        drain();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            rand_req(60);
            alm = ($urandom_range(7) == 0);
            set_rsp(1'($urandom_range(1)));
            step();
        end
        drain();

        // Grant and response to requester 2 in the same cycle.
        rand_req(0);
        req_valid = 4'b0100;
        set_rsp(1'b0);
        step();
        set_rsp(1'b1);
        step();
        set_rsp(1'b0);
        step();
        step();
        drain();

        // Bad ID, then a response to an idle requester.
        c0Rx_rspValid = 1'b1;
        c0Rx_mdata    = 16'hF000;
        rand_data();
        step();
        set_rsp(1'b0);
        step();
        step();
        check("err_sticky", err_bad_id, 1'b1);
        c0Rx_rspValid = 1'b1;
        c0Rx_mdata    = 16'h3123;
        rand_data();
        step();
        set_rsp(1'b0);
        step();

        // Asynchronous reset in the middle of traffic.
        for (int c = 0; c < 5; c++) begin
            rand_req(100);
            set_rsp(1'b1);
            step();
        end
        rst_n = 1'b0;
        model_reset();
        #1 check_zero();
        repeat (3) begin
            @(negedge pClk);
            rand_req(100);
            c0Rx_rspValid = 1'b1;
            c0Rx_mdata    = 16'h0001;
            #1 check_zero();
        end
        @(posedge pClk);
        #1;
        rst_n = 1'b1;
        rand_req(100);
        for (int c = 0; c < 6; c++) begin
            set_rsp(1'b1);
            step();
        end
        drain();
        step();

        check("txq_empty", 32'(txq.size()), 32'd0);
        check("rxq_empty", 32'(rxq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
